// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480 timing constants, mode struct and total helpers
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } timing_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned h_total(timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with carry-out and active/sync decode
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_carry,
    output logic         o_active,
    output logic         o_sync
);
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last   = (r_cnt == LAST);
    assign o_cnt    = r_cnt;
    assign o_carry  = i_en && w_last;
    assign o_active = (r_cnt < W'(ACTIVE));
    assign o_sync   = (r_cnt >= SYNC_LO) && (r_cnt < SYNC_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-enable video timing generator; VGA_TIMING_IRQ_EN enables the vblank irq
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned LOOKAHEAD  = 2,
    localparam timing_t     TIMING  = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP},
    localparam int unsigned H_TOTAL = h_total(TIMING),
    localparam int unsigned V_TOTAL = v_total(TIMING),
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          de_o,
    output logic [HW-1:0] posx_o,
    output logic [VW-1:0] posy_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [HW-1:0] fetch_x_o,
    output logic [VW-1:0] fetch_y_o,
    output logic          fetch_de_o,
    output logic          irq_o,
    input  logic          irq_ack
);
    generate
        if (LOOKAHEAD > H_FP + H_SYNC + H_BP || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
            H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    logic          w_h_carry, w_h_active, w_h_sync;
    logic          w_v_carry, w_v_active, w_v_sync;
    logic          w_unused_v_carry;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_hcnt (
        .clk(clk), .rst(rst), .i_en(pix_ce),
        .o_cnt(w_hcnt), .o_carry(w_h_carry), .o_active(w_h_active), .o_sync(w_h_sync)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_vcnt (
        .clk(clk), .rst(rst), .i_en(w_h_carry),
        .o_cnt(w_vcnt), .o_carry(w_v_carry), .o_active(w_v_active), .o_sync(w_v_sync)
    );

    assign w_unused_v_carry = w_v_carry;

    // LOOKAHEAD never exceeds the blanking width, so one subtraction suffices for the line carry.
    localparam logic [HW-1:0] FX_WRAP_AT = HW'(H_TOTAL - 1 - LOOKAHEAD);
    localparam logic [HW-1:0] FX_ADD     = HW'(LOOKAHEAD);
    localparam logic [HW-1:0] FX_SUB     = HW'(H_TOTAL - LOOKAHEAD);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic          w_fetch_wrap;
    logic [HW-1:0] w_fetch_x;
    logic [VW-1:0] w_fetch_y;
    logic          w_fetch_de;

    assign w_fetch_wrap = (w_hcnt > FX_WRAP_AT);
    assign w_fetch_x    = w_fetch_wrap ? w_hcnt - FX_SUB : w_hcnt + FX_ADD;
    assign w_fetch_y    = !w_fetch_wrap ? w_vcnt : ((w_vcnt == V_LAST) ? '0 : w_vcnt + 1'b1);
    assign w_fetch_de   = (w_fetch_x < HW'(H_ACTIVE)) && (w_fetch_y < VW'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync_o      <= ~H_SYNC_POL;
            v_sync_o      <= ~V_SYNC_POL;
            de_o          <= 1'b0;
            posx_o        <= '0;
            posy_o        <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            fetch_x_o     <= '0;
            fetch_y_o     <= '0;
            fetch_de_o    <= 1'b0;
        end else begin
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            if (pix_ce) begin
                h_sync_o      <= w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
                v_sync_o      <= w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
                de_o          <= w_h_active && w_v_active;
                posx_o        <= w_hcnt;
                posy_o        <= w_vcnt;
                line_start_o  <= (w_hcnt == '0);
                frame_start_o <= (w_hcnt == '0) && (w_vcnt == '0);
                fetch_x_o     <= w_fetch_x;
                fetch_y_o     <= w_fetch_y;
                fetch_de_o    <= w_fetch_de;
            end
        end
    end

`ifdef VGA_TIMING_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    assign w_irq_set = pix_ce && (w_hcnt == '0) && (w_vcnt == VW'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq_ack;
    assign w_unused_irq_ack = irq_ack;
    assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced 30x17 timing
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 3, HS = 5, HB = 6;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int LA = 2;
    localparam int HT = 30, VT = 17, FT = 510;

`ifdef VGA_TIMING_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [4:0] x;
        logic [4:0] y;
        logic       ls;
        logic       fs;
        logic [4:0] fx;
        logic [4:0] fy;
        logic       fde;
        logic       irq;
    } out_t;

    // hand-computed lookahead vectors: presented (x,y) -> fetch (x,y,de)
    localparam int DPX[6] = '{28, 29, 14, 13, 29, 28};
    localparam int DPY[6] = '{3, 16, 9, 9, 9, 16};
    localparam int DFX[6] = '{0, 1, 16, 15, 1, 0};
    localparam int DFY[6] = '{4, 0, 9, 9, 10, 0};
    localparam int DFD[6] = '{1, 1, 0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_ce = 1'b0;
    logic       irq_ack = 1'b0;
    logic       h_sync_o, v_sync_o, de_o, line_start_o, frame_start_o, fetch_de_o, irq_o;
    logic [4:0] posx_o, posy_o, fetch_x_o, fetch_y_o;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LOOKAHEAD(LA)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .de_o(de_o),
        .posx_o(posx_o), .posy_o(posy_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o),
        .fetch_x_o(fetch_x_o), .fetch_y_o(fetch_y_o), .fetch_de_o(fetch_de_o),
        .irq_o(irq_o), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    out_t q[$];
    out_t last_e;
    int   m_p = 0;
    logic m_irq = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   phase = 0;

    task automatic cyc(input logic ce, input logic r, input logic ack);
        out_t e;
        int x, y, fp;
        pix_ce  = ce;
        rst     = r;
        irq_ack = ack;
        @(posedge clk);
        e = last_e;
        e.ls = 1'b0;
        e.fs = 1'b0;
        if (r) begin
            e = '0;
            e.hs = 1'b1;
            e.vs = 1'b1;
            m_p = 0;
            m_irq = 1'b0;
        end else if (ce) begin
            x  = m_p % HT;
            y  = m_p / HT;
            fp = (m_p + LA) % FT;
            e.hs  = !(x >= 19 && x < 24);
            e.vs  = !(y >= 12 && y < 14);
            e.de  = (x < 16) && (y < 10);
            e.x   = 5'(x);
            e.y   = 5'(y);
            e.ls  = (x == 0);
            e.fs  = (m_p == 0);
            e.fx  = 5'(fp % HT);
            e.fy  = 5'(fp / HT);
            e.fde = ((fp % HT) < 16) && ((fp / HT) < 10);
            if (IRQ_EN && x == 0 && y == 10) m_irq = 1'b1;
            else if (ack) m_irq = 1'b0;
            m_p = (m_p + 1) % FT;
        end else if (ack) begin
            m_irq = 1'b0;
        end
        e.irq = m_irq;
        last_e = e;
        q.push_back(e);
        #1;
    endtask

    out_t mon_a, mon_e;
    int   cyc_n = 0;
    int   mon_phase = 0;
    int   last_fs = -1;
    int   de_cnt = 0;
    logic prev_fs = 1'b0;

    always @(negedge clk) begin
        mon_a = {h_sync_o, v_sync_o, de_o, posx_o, posy_o, line_start_o, frame_start_o,
                 fetch_x_o, fetch_y_o, fetch_de_o, irq_o};
        cyc_n++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs cyc%0d actual=%h expected=%h", cyc_n, mon_a, mon_e);
            end
            for (int i = 0; i < 6; i++) begin
                if (int'(posx_o) == DPX[i] && int'(posy_o) == DPY[i]) begin
                    checks++;
                    if (int'(fetch_x_o) != DFX[i] || int'(fetch_y_o) != DFY[i] || int'(fetch_de_o) != DFD[i]) begin
                        failures++;
                        $display("FAIL fetch_vec%0d actual=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", i,
                                 fetch_x_o, fetch_y_o, fetch_de_o, DFX[i], DFY[i], DFD[i]);
                    end
                end
            end
        end
        if (phase != mon_phase) begin
            mon_phase = phase;
            last_fs = -1;
        end
        if (frame_start_o) begin
            checks++;
            if (prev_fs) begin
                failures++;
                $display("FAIL fs_width actual=2+ expected=1");
            end
            if (mon_phase != 0 && last_fs >= 0) begin
                checks += 2;
                if (cyc_n - last_fs != (mon_phase == 1 ? FT : 2 * FT)) begin
                    failures++;
                    $display("FAIL frame_period actual=%0d expected=%0d", cyc_n - last_fs, (mon_phase == 1 ? FT : 2 * FT));
                end
                if (de_cnt != (mon_phase == 1 ? 160 : 320)) begin
                    failures++;
                    $display("FAIL de_count actual=%0d expected=%0d", de_cnt, (mon_phase == 1 ? 160 : 320));
                end
            end
            last_fs = cyc_n;
            de_cnt = 0;
        end
        if (de_o) de_cnt++;
        prev_fs = frame_start_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        phase = 1;
        repeat (3 * FT + 5) cyc(1'b1, 1'b0, 1'b0);
        phase = 2;
        repeat (3 * FT + 5) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        phase = 0;
        while (m_p != 10 * HT) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        while (m_p != 10 * HT) cyc(1'b1, 1'b0, 1'b0);
        repeat (50) cyc(1'b1, 1'b0, 1'b0);
        while (m_p != 5 * HT + 10) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (40) cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
